// File: rtl/credit_pkg.sv
// Shared constants, width helper and count type for the credit link.
package credit_pkg;

  localparam int DEFAULT_MAX_CREDITS = 8;

  // Width needed to hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_MAX_CREDITS);

  typedef logic [DEFAULT_CNT_W-1:0] credit_cnt_t;

endpackage

// File: rtl/credit_tx_gate_if.sv
// Bundle of upstream, downstream and credit-return signals for credit_tx_gate.
interface credit_tx_gate_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 4
);

  logic                  flush_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  credit_i;
  logic [CNT_W-1:0]      credits_o;
  logic                  no_credit_o;
  logic                  overflow_err_o;

  modport master (
    output flush_i, valid_i, data_i, credit_i,
    input  ready_o, valid_o, data_o, credits_o, no_credit_o, overflow_err_o
  );

  modport slave (
    input  flush_i, valid_i, data_i, credit_i,
    output ready_o, valid_o, data_o, credits_o, no_credit_o, overflow_err_o
  );

endinterface

// File: rtl/sat_credit_counter.sv
// Up/down credit counter with synchronous reset to INIT, saturation at MAX and a
// sticky overflow flag. Simultaneous inc and dec cancel.
module sat_credit_counter
  import credit_pkg::*;
#(
  parameter int MAX   = DEFAULT_MAX_CREDITS,
  parameter int INIT  = MAX,
  parameter int CNT_W = cnt_w(MAX)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX_CNT) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + ONE;
    end else if (dec_i && !inc_i) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= INIT_CNT;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/credit_tx_gate.sv
// Transmit side of a credit-based link: valid/ready upstream, valid-only registered
// downstream, stalls when credits run out. Optional macro CREDIT_TX_BYPASS_EN lets a
// credit returned at count 0 be spent in the same cycle.
module credit_tx_gate
  import credit_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_CREDITS  = DEFAULT_MAX_CREDITS,
  parameter int INIT_CREDITS = MAX_CREDITS
) (
  input logic clk_i,
  input logic rst_i,
  credit_tx_gate_if.slave bus
);

  localparam int CNT_W = cnt_w(MAX_CREDITS);

  logic [CNT_W-1:0]      credits;
  logic                  overflow;
  logic                  ready;
  logic                  accept;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

`ifdef CREDIT_TX_BYPASS_EN
  // A returning credit may be spent immediately; inc/dec then cancel in the counter.
  assign ready = !rst_i && !bus.flush_i && ((credits != '0) || bus.credit_i);
`else
  assign ready = !rst_i && !bus.flush_i && (credits != '0);
`endif

  assign accept = bus.valid_i && ready;

  sat_credit_counter #(
    .MAX   (MAX_CREDITS),
    .INIT  (INIT_CREDITS),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .inc_i      (bus.credit_i),
    .dec_i      (accept),
    .cnt_o      (credits),
    .overflow_o (overflow)
  );

  always_comb begin
    valid_d = accept;
    data_d  = data_q;
    if (accept) data_d = bus.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.ready_o        = ready;
  assign bus.valid_o        = valid_q;
  assign bus.data_o         = data_q;
  assign bus.credits_o      = credits;
  assign bus.no_credit_o    = (credits == '0);
  assign bus.overflow_err_o = overflow;

endmodule

// File: doc/credit_tx_gate.md
Name: credit_tx_gate

Overview:
Transmitter end of a credit-based point-to-point link between pipeline stages.
- Accepts items from an upstream valid/ready producer and forwards them through a single output register as valid-only transfers.
- Tracks downstream buffer credits and stalls upstream when no credit remains.
- The receiver returns one credit per freed slot on credit_i.

Parameters:
DATA_WIDTH, 32, payload width in bits
MAX_CREDITS, 8, receiver buffer depth; upper bound on the credit count
INIT_CREDITS, MAX_CREDITS, credit count loaded on reset; must be <= MAX_CREDITS
CNT_W, $clog2(MAX_CREDITS+1), credit counter width (derived, localparam)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  blocks upstream acceptance this cycle
valid_i  in  1  upstream item valid
ready_o  out  1  upstream may transfer this cycle
data_i  in  DATA_WIDTH  upstream payload
valid_o  out  1  downstream transfer; one item per high cycle, no ready
data_o  out  DATA_WIDTH  downstream payload, registered
credit_i  in  1  one credit returned per high cycle
credits_o  out  CNT_W  current credit count, registered
no_credit_o  out  1  credits_o == 0
overflow_err_o  out  1  sticky: a credit was returned while the count was already MAX_CREDITS

Behaviour:
- Reset (rst_i high at the clock edge, highest priority):
  - credits_o = INIT_CREDITS
  - valid_o = 0, data_o = 0, overflow_err_o = 0
  - ready_o = 0 while rst_i is high
- Definitions:
  - ready_o = !rst_i && !flush_i && (credits_o != 0)
  - accept = valid_i && ready_o
- Output register:
  - On accept: next cycle valid_o = 1 and data_o = data_i.
  - Otherwise: next cycle valid_o = 0 and data_o holds its previous value.
  - Latency valid_i to valid_o is exactly 1 cycle. Back-to-back accepts give back-to-back valid_o.
- Credit counter, next value:
  - accept && !credit_i: credits - 1
  - !accept && credit_i: credits + 1, saturating at MAX_CREDITS
  - accept && credit_i: unchanged
  - neither: unchanged
- Underflow is impossible because accept requires credits != 0.
- Overflow: credit_i with !accept and credits == MAX_CREDITS keeps the count at MAX_CREDITS and sets overflow_err_o. It stays set until rst_i.
- Credit returned with count 0: ready_o stays 0 that cycle and rises the following cycle. Exception: see Optional Feature.
- flush_i:
  - Forces ready_o = 0 that cycle only.
  - An item already in the output register is still presented; valid_o is not cancelled.
  - credit_i is still counted during flush.
- Reset mid-operation: an in-flight valid_o is dropped. The counter returns to INIT_CREDITS regardless of outstanding credits; the receiver must be reset together with this block.
- no_credit_o is combinational from the registered count.

Optional Feature:
Macro CREDIT_TX_BYPASS_EN.
- Defined:
  - ready_o = !rst_i && !flush_i && (credits_o != 0 || credit_i).
  - A credit returned while the count is 0 is consumed in the same cycle. The counter stays 0 if an accept occurs.
  - Adds a combinational path credit_i -> ready_o.
- Undefined: ready_o depends only on registered state, rst_i and flush_i, as in Behaviour.

Decomposition:
- Shared package credit_pkg:
  - default MAX_CREDITS constant
  - function returning CNT_W for a given depth
  - typedef for the credit count type
- Sub-module sat_credit_counter:
  - CNT_W-bit up/down counter, synchronous active-high reset to a parameter value
  - inc/dec inputs that cancel when both are high
  - saturation at a MAX parameter with an overflow flag output
- credit_tx_gate instantiates sat_credit_counter plus the output register and ready logic.

Test Plan:
1. Reset with INIT_CREDITS=8 -> credits_o=8, valid_o=0, ready_o=1 from the first cycle after rst_i drops.
2. valid_i held high 10 cycles, data 0x0..0x9, no credit_i -> exactly 8 accepts; valid_o high cycles 1-8 carrying 0x0..0x7; ready_o=0 and no_credit_o=1 from cycle 8; data 0x8 held upstream.
3. From state 2, one credit_i pulse -> bypass undefined: ready_o=1 the next cycle, 0x8 accepted, credits_o back to 0; bypass defined: 0x8 accepted in the pulse cycle.
4. credits_o=3, continuous accept with credit_i every cycle for 20 cycles -> credits_o stays 3, 20 items forwarded in order.
5. credits_o=8, credit_i pulsed once with valid_i=0 -> credits_o stays 8, overflow_err_o=1 and stays set until rst_i.
6. flush_i high one cycle while valid_i=1, credits_o=4 -> no accept that cycle; credits_o=4; a prior-cycle item is still emitted on valid_o. Then rst_i mid-stream with credits_o=2 -> next cycle credits_o=8, valid_o=0.
